// File: rtl/bf2i_stage_ctrl.sv
// bf2i_stage_ctrl: sequencer for one radix-2^2 BF2I stage of the
// 8-lane FFT: fill delay memory, butterfly + writeback, then drain.
module bf2i_stage_ctrl #(
  parameter int SPAN = 32,
  parameter int AW   = $clog2(SPAN)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          din_valid,
  input  logic          din_sof,
  output logic          din_ready,
  output logic          bf_en,
  output logic [AW-1:0] mem_raddr,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic          mem_wsel,
  output logic          out_sel,
  output logic          dout_valid,
  output logic          dout_sof,
  output logic          dout_eof,
  output logic          err_sof,
  output logic          busy
);

  localparam logic [AW-1:0] LAST = AW'(SPAN - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    BFLY
  } st_t;

  st_t st, st_nxt;

  logic [AW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] fill_addr;
  logic [AW-1:0] wb_addr;
  logic [AW-1:0] dcnt;
  logic          acc;
  logic          cnt_last;
  logic          new_frm;
  logic          abort;
  logic          bf_acc;
  logic          fill_we;
  logic          wb_v;
  logic          wb_sof;
  logic          wb_we;
  logic          gap;
  logic          dact;
  logic          err_q;

  assign acc      = din_valid & ~gap;
  assign cnt_last = (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st  <= IDLE;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // A sof accepted in any state restarts the frame at address 0.
  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    new_frm   = 1'b0;
    bf_acc    = 1'b0;
    fill_we   = 1'b0;
    fill_addr = cnt;
    unique case (st)
      IDLE: begin
        if (acc && din_sof) new_frm = 1'b1;
      end
      FILL: begin
        if (acc && din_sof) begin
          new_frm = 1'b1;
        end else if (acc) begin
          fill_we = 1'b1;
          cnt_nxt = cnt + ONE;
          if (cnt_last) st_nxt = BFLY;
        end
      end
      BFLY: begin
        if (acc && din_sof) begin
          new_frm = 1'b1;
        end else if (acc) begin
          bf_acc  = 1'b1;
          cnt_nxt = cnt + ONE;
          if (cnt_last) st_nxt = IDLE;
        end
      end
      default: st_nxt = IDLE;
    endcase
    if (new_frm) begin
      st_nxt    = FILL;
      cnt_nxt   = ONE;
      fill_we   = 1'b1;
      fill_addr = '0;
    end
  end

  assign abort = new_frm & (st != IDLE);
  assign wb_we = wb_v & ~new_frm;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_v    <= 1'b0;
      wb_addr <= '0;
      wb_sof  <= 1'b0;
      gap     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wb_v    <= bf_acc;
      wb_addr <= cnt;
      wb_sof  <= (cnt == '0);
      gap     <= bf_acc & cnt_last;
      err_q   <= abort;
    end
  end

  // Drain starts the cycle after the gap and runs SPAN cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dact <= 1'b0;
      dcnt <= '0;
    end else if (gap) begin
      dact <= 1'b1;
      dcnt <= '0;
    end else if (dact) begin
      dcnt <= dcnt + ONE;
      if (dcnt == LAST) dact <= 1'b0;
    end
  end

  assign din_ready  = rstn & ~gap;
  assign bf_en      = rstn & bf_acc;
  assign mem_raddr  = !rstn ? '0 : (dact ? dcnt : cnt);
  assign mem_we     = rstn & (fill_we | wb_we);
  assign mem_waddr  = !rstn ? '0 : (wb_we ? wb_addr : fill_addr);
  assign mem_wsel   = rstn & wb_we;
  assign out_sel    = rstn & dact;
  assign dout_valid = rstn & (wb_we | dact);
  assign dout_sof   = rstn & wb_we & wb_sof;
  assign dout_eof   = rstn & dact & (dcnt == LAST);
  assign err_sof    = rstn & err_q;
  assign busy       = rstn & ((st != IDLE) | dact);

endmodule

// File: tb/tb_bf2i_stage_ctrl.sv
// tb_bf2i_stage_ctrl: vector table plus schedule-based reference
// model driven by directed sequences and random traffic.
module tb_bf2i_stage_ctrl;

  localparam int SPAN = 4;
  localparam int AW   = 2;
  localparam int NC   = 8192;

  logic          clk;
  logic          rstn;
  logic          din_valid;
  logic          din_sof;
  logic          din_ready;
  logic          bf_en;
  logic [AW-1:0] mem_raddr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          mem_wsel;
  logic          out_sel;
  logic          dout_valid;
  logic          dout_sof;
  logic          dout_eof;
  logic          err_sof;
  logic          busy;

  bf2i_stage_ctrl #(.SPAN(SPAN)) dut (
    .clk(clk), .rstn(rstn),
    .din_valid(din_valid), .din_sof(din_sof),
    .din_ready(din_ready), .bf_en(bf_en),
    .mem_raddr(mem_raddr), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wsel(mem_wsel),
    .out_sel(out_sel), .dout_valid(dout_valid),
    .dout_sof(dout_sof), .dout_eof(dout_eof),
    .err_sof(err_sof), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pos      = -1;

  // Per-cycle expected event schedule.
  bit fill_v[NC];
  int fill_a[NC];
  bit wb_v[NC];
  int wb_a[NC];
  bit wb_s[NC];
  bit bf_v[NC];
  int bf_a[NC];
  bit dr_v[NC];
  int dr_a[NC];
  bit dr_e[NC];
  bit err_v[NC];
  bit gap_v[NC];

  typedef struct {
    logic        v;
    logic        s;
    logic [13:0] x;
  } vec_t;

  vec_t tv[14];

  function automatic logic [13:0] mk(
    input int rdy, input int bf, input int ra, input int we,
    input int wa, input int ws, input int os, input int dv,
    input int sf, input int ef, input int er, input int by);
    logic [13:0] x;
    x = {rdy[0], bf[0], ra[1:0], we[0], wa[1:0], ws[0],
         os[0], dv[0], sf[0], ef[0], er[0], by[0]};
    return x;
  endfunction

  function automatic logic [13:0] msk(input logic [13:0] e);
    logic [13:0] m;
    m = '1;
    if (!(e[12] || (e[4] && e[5]))) m[11:10] = 2'b00;
    if (!e[9]) m[8:6] = 3'b000;
    if (!e[4]) m[5] = 1'b0;
    return m;
  endfunction

  function automatic logic [13:0] obs();
    return {din_ready, bf_en, mem_raddr, mem_we, mem_waddr,
            mem_wsel, out_sel, dout_valid, dout_sof, dout_eof,
            err_sof, busy};
  endfunction

  task automatic chk(input string nm, input logic [13:0] e,
                     input bit full);
    logic [13:0] m;
    logic [13:0] o;
    m = full ? '1 : msk(e);
    o = obs();
    checks++;
    if ((o & m) !== (e & m)) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b want=%b mask=%b",
               nm, cyc, o, e, m);
    end
  endtask

  task automatic clr_from(input int c0);
    for (int i = c0; i < NC; i++) begin
      fill_v[i] = 0; wb_v[i] = 0; wb_s[i] = 0;
      bf_v[i] = 0; dr_v[i] = 0; dr_e[i] = 0;
      err_v[i] = 0; gap_v[i] = 0;
    end
  endtask

  task automatic mdl(input logic v, input logic s,
                     output logic [13:0] e, output bit acc);
    int c;
    int k;
    bit by;
    c   = cyc;
    by  = (pos >= 0) || dr_v[c];
    acc = v && !gap_v[c];
    if (acc && s) begin
      if (pos >= 0) begin
        err_v[c+1] = 1;
        wb_v[c] = 0;
      end
      fill_v[c] = 1; fill_a[c] = 0; pos = 1;
    end else if (acc && pos >= 0 && pos < SPAN) begin
      fill_v[c] = 1; fill_a[c] = pos; pos++;
    end else if (acc && pos >= SPAN) begin
      k = pos - SPAN;
      bf_v[c] = 1; bf_a[c] = k;
      wb_v[c+1] = 1; wb_a[c+1] = k; wb_s[c+1] = (k == 0);
      pos++;
      if (pos == 2 * SPAN) begin
        pos = -1;
        gap_v[c+1] = 1;
        for (int j = 0; j < SPAN; j++) begin
          dr_v[c+2+j] = 1;
          dr_a[c+2+j] = j;
          dr_e[c+2+j] = (j == SPAN - 1);
        end
      end
    end
    e = mk(!gap_v[c], bf_v[c], dr_v[c] ? dr_a[c] : bf_a[c],
           fill_v[c] | wb_v[c], wb_v[c] ? wb_a[c] : fill_a[c],
           wb_v[c], dr_v[c], wb_v[c] | dr_v[c],
           wb_v[c] & wb_s[c], dr_v[c] & dr_e[c], err_v[c], by);
  endtask

  task automatic step(input logic v, input logic s, input bit ut,
                      input logic [13:0] te, output bit acc);
    logic [13:0] e;
    din_valid = v;
    din_sof   = s;
    mdl(v, s, e, acc);
    @(negedge clk);
    chk("model", e, 0);
    if (ut) chk("table", te, 0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input logic v, input logic s);
    bit a;
    step(v, s, 0, '0, a);
  endtask

  task automatic send(input logic s);
    bit a;
    int n;
    n = 0;
    do begin
      step(1'b1, s, 0, '0, a);
      n++;
    end while (!a && n < 4);
    if (!a) begin
      checks++;
      failures++;
      $display("FAIL send_timeout cyc=%0d got=stalled want=accept",
               cyc);
    end
  endtask

  task automatic frame();
    for (int i = 0; i < 2 * SPAN; i++) send(i == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(1'b0, 1'b0);
  endtask

  task automatic do_rst();
    din_valid = 1'b1;
    din_sof   = 1'b1;
    rstn      = 1'b0;
    #1;
    chk("rst_async", '0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", '0, 1);
    din_valid = 1'b0;
    din_sof   = 1'b0;
    rstn      = 1'b1;
    @(posedge clk);
    #1;
    cyc += 4;
    pos = -1;
    clr_from(cyc);
  endtask

  initial begin
    bit a;
    tv[0]  = '{1'b1, 1'b1, mk(1,0,0,1,0,0,0,0,0,0,0,0)};
    tv[1]  = '{1'b1, 1'b0, mk(1,0,0,1,1,0,0,0,0,0,0,1)};
    tv[2]  = '{1'b1, 1'b0, mk(1,0,0,1,2,0,0,0,0,0,0,1)};
    tv[3]  = '{1'b1, 1'b0, mk(1,0,0,1,3,0,0,0,0,0,0,1)};
    tv[4]  = '{1'b1, 1'b0, mk(1,1,0,0,0,0,0,0,0,0,0,1)};
    tv[5]  = '{1'b1, 1'b0, mk(1,1,1,1,0,1,0,1,1,0,0,1)};
    tv[6]  = '{1'b1, 1'b0, mk(1,1,2,1,1,1,0,1,0,0,0,1)};
    tv[7]  = '{1'b1, 1'b0, mk(1,1,3,1,2,1,0,1,0,0,0,1)};
    tv[8]  = '{1'b0, 1'b0, mk(0,0,0,1,3,1,0,1,0,0,0,0)};
    tv[9]  = '{1'b0, 1'b0, mk(1,0,0,0,0,0,1,1,0,0,0,1)};
    tv[10] = '{1'b0, 1'b0, mk(1,0,1,0,0,0,1,1,0,0,0,1)};
    tv[11] = '{1'b0, 1'b0, mk(1,0,2,0,0,0,1,1,0,0,0,1)};
    tv[12] = '{1'b0, 1'b0, mk(1,0,3,0,0,0,1,1,0,1,0,1)};
    tv[13] = '{1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0)};

    rstn      = 1'b0;
    din_valid = 1'b1;
    din_sof   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_init", '0, 1);
    din_valid = 1'b0;
    din_sof   = 1'b0;
    rstn      = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++)
      step(tv[i].v, tv[i].s, 1, tv[i].x, a);

    // back-to-back frames, valid held high
    for (int f = 0; f < 3; f++) frame();
    idle(2 * SPAN);

    // valid toggling during fill and butterfly
    for (int i = 0; i < 2 * SPAN; i++) begin
      go(1'b1, i == 0);
      go(1'b0, 1'b0);
    end
    idle(2 * SPAN);

    // sof on vector #5, then on BFLY cnt 0
    for (int i = 0; i < SPAN + 1; i++) send(i == 0);
    frame();
    idle(2 * SPAN);
    for (int i = 0; i < SPAN; i++) send(i == 0);
    frame();
    idle(2 * SPAN);

    // non-sof vectors in IDLE are discarded
    repeat (3) go(1'b1, 1'b0);
    frame();
    idle(2 * SPAN);

    // reset during the second drain cycle
    frame();
    go(1'b1, 1'b0);
    go(1'b0, 1'b0);
    do_rst();
    repeat (4) go(1'b1, 1'b0);
    idle(4);
    frame();
    idle(2 * SPAN);

    for (int i = 0; i < 2000; i++) begin
      go(($urandom % 4) != 0, ($urandom % 24) == 0);
      if (i == 1234) do_rst();
    end
    idle(3 * SPAN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bf2i_stage_ctrl.md
Name: bf2i_stage_ctrl

Overview:
- Sequencer for one radix-2^2 BF2I stage of the 8-lane parallel FFT.
- Schedules writes of the first half-frame into the stage delay memory, enables the 8-lane butterfly for the second half-frame, writes the subtract results back, then drains them.
- Drives the butterfly enable, the memory controls and the output mux/valid. It carries no sample data itself.
- Sits between the upstream stage's vector stream and the butterfly-plus-delay-memory datapath.

Parameters:
- SPAN, 32, butterfly span in 8-sample vectors (half-frame length). Must be a power of two, ≥2.
- AW, $clog2(SPAN), memory address width.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- din_valid  input  1  input vector valid
- din_sof  input  1  first vector of a frame, qualified by din_valid
- din_ready  output  1  input accept. A vector is accepted when din_valid && din_ready.
- bf_en  output  1  butterfly enable; the butterfly output is registered with 1-cycle latency
- mem_raddr  output  AW  delay-memory read address (asynchronous read)
- mem_we  output  1  delay-memory write strobe (synchronous write)
- mem_waddr  output  AW  delay-memory write address
- mem_wsel  output  1  write data select: 0 = input vector, 1 = butterfly sub result
- out_sel  output  1  output mux select: 0 = butterfly add result, 1 = memory read data
- dout_valid  output  1  output vector valid
- dout_sof  output  1  first output vector of a frame
- dout_eof  output  1  last output vector of a frame
- err_sof  output  1  one-cycle pulse when a frame is aborted by an unexpected sof
- busy  output  1  high when the input FSM is not IDLE or a drain is active

Behaviour:
- Reset: input FSM goes to IDLE and all counters go to 0. While rstn is low, every output is 0, including din_ready.
- din_ready is combinational and is 1 except in the single GAP cycle described below.
- Input FSM states are IDLE, FILL and BFLY. Counter cnt (AW bits) advances only on accepted vectors.
- IDLE:
  - Accepted vector with din_sof=1: mem_we=1, mem_wsel=0, mem_waddr=0; cnt←1; go to FILL.
  - Accepted vector with din_sof=0: discarded, no other action.
- FILL, on each accepted vector:
  - mem_we=1, mem_wsel=0, mem_waddr=cnt, cnt++.
  - On the accept with cnt==SPAN-1: cnt←0, go to BFLY.
- BFLY, on each accepted vector:
  - mem_raddr=cnt, bf_en=1 in the same cycle.
  - Next cycle (writeback stage): dout_valid=1, out_sel=0, mem_we=1, mem_wsel=1, mem_waddr=the previous cnt.
  - dout_sof=1 on the writeback of cnt==0.
  - On the accept with cnt==SPAN-1: start the drain, go to IDLE.
- bf_en is 0 in every cycle without a BFLY accept. Butterfly idle outputs are ignored because dout_valid=0.
- GAP: din_ready=0 in the cycle immediately after the last BFLY accept, so the next frame's address-0 fill cannot precede the drain read of address 0.
- Drain runs SPAN consecutive cycles starting 2 cycles after the last BFLY accept, independent of din_valid.
  - Each drain cycle: mem_raddr=dcnt, out_sel=1, dout_valid=1.
  - dout_eof=1 on dcnt==SPAN-1.
- Overlap: FILL of the next frame may run during drain.
  - mem_raddr is owned by the drain, because FILL does not read.
  - Fill writes address k no earlier than the drain reads k. A same-cycle read and write at k returns old data.
- Latency: first output is 1 cycle after the first BFLY accept. Frame output is SPAN add vectors (gaps follow input gaps) then SPAN drain vectors (contiguous). There is no output backpressure.
- Abort:
  - Trigger: an accepted din_sof=1 while in FILL, or in BFLY with cnt≠0.
  - err_sof pulses the next cycle.
  - The vector is treated as a new frame start: write address 0, cnt←1, state FILL.
  - The pending writeback from the previous cycle's accept is suppressed (no mem_we, no dout_valid). The aborted frame is never drained.
- din_sof=1 at BFLY cnt==0 is also an abort.
- An active drain is never aborted.
- An asynchronous reset mid-frame or mid-drain drops all in-flight work; nothing is output after release until a new sof.

Test Plan:
- SPAN=4, 8 contiguous vectors with sof on #0:
  - mem_we with wsel=0 at addresses 0..3.
  - bf_en on vectors 4..7; dout_valid add outputs with sof on the first.
  - GAP cycle.
  - 4 drain cycles at raddr 0..3 with eof on the last.
- Back-to-back frames with din_valid held high: din_ready low exactly 1 cycle. The second frame's fill writes address k in the same cycle as or after the drain reads k, and no output collisions occur.
- din_valid toggling every other cycle during FILL/BFLY: counters stall. Add outputs follow the gaps, then the drain is 4 contiguous cycles.
- sof on vector #5 (BFLY cnt=1):
  - err_sof pulses once.
  - No writeback/dout for vector #5's predecessor's slot after the abort.
  - New frame fills from address 0.
- IDLE with non-sof vectors: discarded, busy=0, no mem_we. Then a sof frame proceeds normally.
- rstn asserted during drain cycle 2: all outputs 0 immediately. After release, no dout until a new sof frame.
